// File: rtl/dec_ex_pipeline_reg.sv
// dec_ex_pipeline_reg: decode-to-execute pipeline register for the 5-stage core.
// Latches the decoded bundle into EX, inserts zero-encoded bubbles on flush or
// when decode is empty, and holds on stall. One action per edge, in priority
// order rst > flush > stall > load. Reset is synchronous, active-high.
// Optional feature: define DEC_EX_STATS_EN to compile in three 32-bit event
// counters (instructions loaded, flushes, stalls) and their output ports.
module dec_ex_pipeline_reg #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall,
  input  logic                dec_valid,
  input  logic [XLEN-1:0]     dec_pc,
  input  logic [XLEN-1:0]     dec_pc_plus4,
  input  logic [XLEN-1:0]     dec_rs1_data,
  input  logic [XLEN-1:0]     dec_rs2_data,
  input  logic [XLEN-1:0]     dec_imm,
  input  logic [4:0]          dec_rs1_addr,
  input  logic [4:0]          dec_rs2_addr,
  input  logic [4:0]          dec_rd_addr,
  input  logic                dec_reg_write,
  input  logic                dec_mem_write,
  input  logic                dec_mem_read,
  input  logic                dec_branch,
  input  logic                dec_jump,
  input  logic                dec_alu_src,
  input  logic [1:0]          dec_result_src,
  input  logic [ALU_OP_W-1:0] dec_alu_op,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_pc_plus4,
  output logic [XLEN-1:0]     ex_rs1_data,
  output logic [XLEN-1:0]     ex_rs2_data,
  output logic [XLEN-1:0]     ex_imm,
  output logic [4:0]          ex_rs1_addr,
  output logic [4:0]          ex_rs2_addr,
  output logic [4:0]          ex_rd_addr,
  output logic                ex_reg_write,
  output logic                ex_mem_write,
  output logic                ex_mem_read,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_alu_src,
  output logic [1:0]          ex_result_src,
  output logic [ALU_OP_W-1:0] ex_alu_op
`ifdef DEC_EX_STATS_EN
  ,
  output logic [31:0]         stat_instr_count,
  output logic [31:0]         stat_flush_count,
  output logic [31:0]         stat_stall_count
`endif
);

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned RESULT_SRC_W = 2;
  localparam int unsigned STAT_W       = 32;

  // Full EX slot; the all-zero value is the bubble encoding.
  typedef struct packed {
    logic                    valid;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         pc_plus4;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic [XLEN-1:0]         imm;
    logic [REG_ADDR_W-1:0]   rs1_addr;
    logic [REG_ADDR_W-1:0]   rs2_addr;
    logic [REG_ADDR_W-1:0]   rd_addr;
    logic                    reg_write;
    logic                    mem_write;
    logic                    mem_read;
    logic                    branch;
    logic                    jump;
    logic                    alu_src;
    logic [RESULT_SRC_W-1:0] result_src;
    logic [ALU_OP_W-1:0]     alu_op;
  } ex_bundle_t;

  ex_bundle_t dec_bundle_c;
  ex_bundle_t ex_d;
  ex_bundle_t ex_q;

  // Gather the decode fields into one slot image.
  always_comb begin
    dec_bundle_c            = '0;
    dec_bundle_c.valid      = dec_valid;
    dec_bundle_c.pc         = dec_pc;
    dec_bundle_c.pc_plus4   = dec_pc_plus4;
    dec_bundle_c.rs1_data   = dec_rs1_data;
    dec_bundle_c.rs2_data   = dec_rs2_data;
    dec_bundle_c.imm        = dec_imm;
    dec_bundle_c.rs1_addr   = dec_rs1_addr;
    dec_bundle_c.rs2_addr   = dec_rs2_addr;
    dec_bundle_c.rd_addr    = dec_rd_addr;
    dec_bundle_c.reg_write  = dec_reg_write;
    dec_bundle_c.mem_write  = dec_mem_write;
    dec_bundle_c.mem_read   = dec_mem_read;
    dec_bundle_c.branch     = dec_branch;
    dec_bundle_c.jump       = dec_jump;
    dec_bundle_c.alu_src    = dec_alu_src;
    dec_bundle_c.result_src = dec_result_src;
    dec_bundle_c.alu_op     = dec_alu_op;
  end

  // Next slot: reset/flush/empty decode all yield the zero bubble, which keeps
  // controls gated by valid and register addresses at x0 for the hazard unit.
  always_comb begin
    ex_d = '0;
    if (rst) begin
      ex_d = '0;
    end else if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (dec_valid) begin
      ex_d = dec_bundle_c;
    end else begin
      ex_d = '0;
    end
  end

  // Slot register; reset is folded into ex_d so this is a plain flop bank.
  always_ff @(posedge clk) begin
    ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1_addr   = ex_q.rs1_addr;
  assign ex_rs2_addr   = ex_q.rs2_addr;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_result_src = ex_q.result_src;
  assign ex_alu_op     = ex_q.alu_op;

`ifdef DEC_EX_STATS_EN
  logic              load_valid_c;
  logic              flush_evt_c;
  logic              stall_evt_c;
  logic [STAT_W-1:0] instr_cnt_q;
  logic [STAT_W-1:0] flush_cnt_q;
  logic [STAT_W-1:0] stall_cnt_q;

  // Counter events follow the same priority as the slot action.
  always_comb begin
    load_valid_c = 1'b0;
    flush_evt_c  = 1'b0;
    stall_evt_c  = 1'b0;
    if (!rst) begin
      if (flush) begin
        flush_evt_c = 1'b1;
      end else if (stall) begin
        stall_evt_c = 1'b1;
      end else begin
        load_valid_c = dec_valid;
      end
    end
  end

  // Event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_valid_c) instr_cnt_q <= instr_cnt_q + STAT_W'(1);
      if (flush_evt_c)  flush_cnt_q <= flush_cnt_q + STAT_W'(1);
      if (stall_evt_c)  stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

  assign stat_instr_count = instr_cnt_q;
  assign stat_flush_count = flush_cnt_q;
  assign stat_stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/dec_ex_pipeline_reg.md
# dec_ex_pipeline_reg

Decode-to-execute pipeline register for the 5-stage core. It latches the decoded instruction bundle from decode into execute, and is the receiving end of the hazard unit's `flush_dec_ex_pipeline` control. It inserts bubbles on flush, holds on stall, and supplies the `ex_rs*/ex_rd` addresses back to the hazard unit for forwarding. Flushed or bubbled slots must never assert a write, memory or branch control, and must never drive a nonzero register address.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `ALU_OP_W`, 4, ALU operation code width

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: core clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `flush` input 1: from `flush_dec_ex_pipeline`; insert bubble
- `stall` input 1: hold current EX contents
- `dec_valid` input 1: decode slot holds a real instruction
- `dec_pc`, `dec_pc_plus4`, `dec_rs1_data`, `dec_rs2_data`, `dec_imm` input XLEN each: decode data fields
- `dec_rs1_addr`, `dec_rs2_addr`, `dec_rd_addr` input 5 each: register addresses
- `dec_reg_write`, `dec_mem_write`, `dec_mem_read`, `dec_branch`, `dec_jump`, `dec_alu_src` input 1 each: control bits
- `dec_result_src` input 2: writeback source select
- `dec_alu_op` input ALU_OP_W: ALU operation
- `ex_*` output, widths matching each `dec_*` input: registered copies, including `ex_valid`
- `stat_instr_count`, `stat_flush_count`, `stat_stall_count` output 32 each: present only with the macro

## Operation
- Each rising edge applies exactly one action, in this priority order: `rst` > `flush` > `stall` > load.
- Reset: every `ex_*` output goes to 0, including `ex_valid`, all addresses, data and controls.
- Flush: bubble.
  - `ex_valid`=0; all control bits, `ex_result_src` and `ex_alu_op` = 0.
  - `ex_rs1_addr`, `ex_rs2_addr`, `ex_rd_addr` = 0, so the hazard unit cannot forward to or from the bubble.
  - Data fields = 0.
- Stall: all `ex_*` registers hold their value, including a held bubble.
- Load: all `ex_*` outputs take the `dec_*` inputs.
  - If `dec_valid`=0, the slot is loaded as a bubble, identical to a flush encoding, except that it is counted as neither instruction nor flush.
- Gating invariant: `ex_reg_write`, `ex_mem_write`, `ex_mem_read`, `ex_branch` and `ex_jump` are 1 only when `ex_valid`=1.
- `flush` together with `stall` in the same cycle gives a bubble; flush wins.
- Back-to-back flushes: each cycle produces a bubble; no accumulated state.
- Reset during a stall or flush: reset wins and the next state is the reset state.

## Timing
- Latency 1 cycle: `dec_*` sampled at edge N appears on `ex_*` after edge N.
- All outputs are registered; there is no combinational path from any input to any output.
- `flush` asserted at edge N: `ex_valid`=0 from edge N until the next load.
- `stall` held for K cycles: outputs are constant for K cycles, and a load occurs on the first edge with `stall`=0.

## Configuration
- `DEC_EX_STATS_EN` defined: three 32-bit counters are compiled in, all cleared by `rst`, with priority matching the register action.
  - `stat_instr_count` increments on each load with `dec_valid`=1.
  - `stat_flush_count` increments on each edge with `flush`=1 and `rst`=0.
  - `stat_stall_count` increments on each edge with `stall`=1, `flush`=0 and `rst`=0.
  - All counters wrap modulo 2^32 (0xFFFFFFFF to 0).
- Not defined: counter ports and logic are absent; the pipeline behaviour is identical.

## Test plan
- Reset then load: `rst`=1 for 2 cycles forces all `ex_*`=0. Then load `dec_pc`=0x100, rd=5, `reg_write`=1, `dec_valid`=1: the next cycle shows `ex_pc`=0x100, `ex_rd_addr`=5, `ex_valid`=1.
- Flush: a valid `sw` in decode (rs1=2, rs2=3, `mem_write`=1) with `flush`=1 gives `ex_mem_write`=0, `ex_rs1_addr`=0, `ex_rs2_addr`=0 and `ex_valid`=0 the next cycle.
- Stall hold: load `dec_imm`=0xFFFFF800, then stall 3 cycles while the `dec_*` inputs change every cycle. `ex_imm` stays 0xFFFFF800 for 3 cycles, then takes the new decode value on release.
- Simultaneous `flush` and `stall` with valid decode data: a bubble results. The next cycle with both low loads normally.
- Bubble passthrough: `dec_valid`=0 with `dec_reg_write`=1 and `dec_rd_addr`=7 gives `ex_reg_write`=0 and `ex_rd_addr`=0.
- Stats (`DEC_EX_STATS_EN`):
  - Stimulus: 10 valid loads, 2 flushes, 3 stalls, then `rst`.
  - Before `rst`: `stat_instr_count`/`stat_flush_count`/`stat_stall_count` read 10/2/3.
  - After `rst`: all three read 0.
  - Preloading 0xFFFFFFFF via a force, followed by one valid load, wraps `stat_instr_count` to 0.
